apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
// - Synthesizable APB slave memory directly downstream of Bridge_Top. It consumes Pselx/Penable/Pwrite/Paddr/Pwdata
//   and produces Prdata for the bridge's APB read path.
// - Replaces the constant-Prdata stub in ahb_apb_top so write-then-read traffic through the bridge is end-to-end checkable.
// - Also reports APB protocol violations and transfer counts for the scoreboard.
// PARAMETERS
// - SLV_IDX   default 0             Pselx bit that selects this slave.
// - BASE_ADDR default 32'h8000_0000 Decode window base (aligned to window size).
// - DEPTH     default 256           32-bit words stored (power of 2).
// - ERR_DATA  default 32'hDEAD_BEEF Prdata value for reads outside the window.
// PORTS
// - Pclk        in   1   APB clock; all state updates on posedge.
// - Preset      in   1   Asynchronous reset, active-high.
// - Pselx       in   3   One-hot slave selects from the bridge.
// - Penable     in   1   APB access phase.
// - Pwrite      in   1   1 = write, 0 = read.
// - Paddr       in   32  Byte address.
// - Pwdata      in   32  Write data.
// - Prdata      out  32  Read data, valid in ACCESS.
// - err_clr     in   1   Synchronous clear of proto_err.
// - proto_err   out  1   Sticky protocol-violation flag.
// - decode_err  out  1   One-cycle pulse: ACCESS to an out-of-window address.
// - wr_cnt      out  16  Completed writes, saturating.
// - rd_cnt      out  16  Completed reads, saturating.
// BEHAVIOUR
// - Reset values: Prdata = 0, proto_err = 0, decode_err = 0, wr_cnt = 0, rd_cnt = 0, FSM = IDLE.
//   Memory contents are not reset.
// - sel = Pselx[SLV_IDX].
// - in_win = (Paddr & ~(DEPTH*4-1)) == BASE_ADDR.
// - idx = Paddr[2 +: $clog2(DEPTH)]. Paddr[1:0] is ignored.
// - FSM states and transitions (state is the registered phase):
//   - IDLE -> SETUP on sel & !Penable.
//   - IDLE -> ACCESS on sel & Penable (violation: sets proto_err; no transfer is performed).
//   - SETUP -> ACCESS on sel & Penable.
//   - SETUP -> SETUP on sel & !Penable (violation; restart the setup phase).
//   - SETUP -> IDLE on !sel (violation).
//   - ACCESS -> SETUP on sel & !Penable (back-to-back transfer).
//   - ACCESS -> IDLE on !sel.
//   - ACCESS -> ACCESS on sel & Penable (violation: no wait states exist, so the transfer is not repeated).
// - In SETUP, latch Paddr, Pwrite and Pwdata.
//   - Any difference on the ACCESS cycle sets proto_err; the transfer uses the latched values.
// - Read: on the SETUP-phase edge, Prdata <= in_win ? mem[idx] : ERR_DATA.
//   - Prdata is therefore valid for the whole ACCESS cycle (zero added latency).
//   - Prdata holds until the next read SETUP.
// - Write: on the ACCESS-phase edge with latched Pwrite = 1 and in_win, mem[idx] <= latched Pwdata.
//   - Out-of-window writes are dropped.
// - decode_err pulses for one cycle after any out-of-window ACCESS (read or write).
// - Counters: increment on each legal ACCESS completion, window hit or miss. They saturate at 16'hFFFF.
// - Read-after-write to the same idx in back-to-back transfers:
//   - The write commits on its ACCESS edge, before the following read's SETUP edge.
//   - The read therefore returns the new data; no bypass is needed.
// - err_clr together with a new violation in the same cycle: set wins.
// - Reset mid-transfer: FSM returns to IDLE and outputs take their reset values.
//   - A partially latched write is discarded.
// - Pselx is not checked for one-hot; only bit SLV_IDX is used.
// STRUCTURE
// - Package apb_slv_pkg:
//   - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e
//   - localparams APB_AW = 32, APB_DW = 32, CNT_W = 16
// - One sub-module, apb_slv_mem_array: single-port DEPTH x 32 register array.
//   - Write port and read port both on Pclk; no reset.
// - FSM, latches, checker and counters stay in apb_slave_mem.
// TESTING
// - Write 32'hA5A5_0001 to 32'h8000_0010, then read it back -> Prdata = 32'hA5A5_0001 in ACCESS; wr_cnt = 1, rd_cnt = 1.
// - Back-to-back write then read at 32'h8000_03FC (last word, idx 255) -> read returns the new data; no IDLE cycle required.
// - Read 32'h9000_0000 -> Prdata = 32'hDEAD_BEEF, decode_err high one cycle, no memory change.
// - Penable asserted with sel from IDLE -> proto_err = 1 and stays set. Assert err_clr -> proto_err = 0 next edge.
// - Paddr changes 32'h8000_0004 -> 32'h8000_0008 between SETUP and ACCESS of a write -> proto_err = 1; only idx 1 is written.
// - Assert Preset during ACCESS of a write -> outputs return to reset values; the target word keeps its old value.

Source files
------------

// File: rtl/apb_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : apb_slv_pkg
// Desc     : Shared types, bus widths and decode helper for the APB slave
//            memory block.
// Revision : 1.0 - initial release
// ============================================================================
package apb_slv_pkg;

   localparam int APB_AW = 32;
   localparam int APB_DW = 32;
   localparam int CNT_W  = 16;

   // Registered APB phase: the phase the bus was in during the previous cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Window hit test: the address, with its in-window offset bits cleared,
   // must equal the (aligned) base address.
   function automatic logic addr_in_win(input logic [APB_AW-1:0] addr,
                                        input logic [APB_AW-1:0] base,
                                        input logic [APB_AW-1:0] mask);
      return ((addr & mask) == base);
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Interface : apb_slave_mem_if
// Desc      : APB bus signals between the bridge (master) and the slave
//             memory (slave).
// Revision  : 1.0 - initial release
// ============================================================================
interface apb_slave_mem_if;
   import apb_slv_pkg::*;

   logic [2:0]        Pselx;
   logic              Penable;
   logic              Pwrite;
   logic [APB_AW-1:0] Paddr;
   logic [APB_DW-1:0] Pwdata;
   logic [APB_DW-1:0] Prdata;

   modport master (
      output Pselx,
      output Penable,
      output Pwrite,
      output Paddr,
      output Pwdata,
      input  Prdata
   );

   modport slave (
      input  Pselx,
      input  Penable,
      input  Pwrite,
      input  Paddr,
      input  Pwdata,
      output Prdata
   );

endinterface
`default_nettype wire

// File: rtl/apb_slave_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : apb_slv_mem_array
// Desc     : Single-port DEPTH x 32 register array. Writes are clocked; the
//            read word is presented combinationally so that the owner can
//            capture it in its own (resettable) read-data register on the
//            same Pclk edge.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slv_mem_array
   import apb_slv_pkg::*;
#(
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  wire logic              clk,
   input  wire logic              we,
   input  wire logic [AW-1:0]     addr,
   input  wire logic [APB_DW-1:0] wdata,
   output logic      [APB_DW-1:0] rdata
);

   logic [APB_DW-1:0] r_mem [DEPTH];

   // Storage update; contents deliberately have no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

   assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_mem
// Desc     : APB slave memory. Tracks the APB phase, latches the SETUP-phase
//            command, reads on the SETUP edge (data valid through ACCESS),
//            writes on the ACCESS edge, flags protocol violations and
//            out-of-window accesses, and counts completed transfers.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem
   import apb_slv_pkg::*;
#(
   parameter int                SLV_IDX   = 0,
   parameter logic [APB_AW-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                DEPTH     = 256,
   parameter logic [APB_DW-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
   input  wire logic             Pclk,
   input  wire logic             Preset,
   apb_slave_mem_if.slave        bus,
   input  wire logic             err_clr,
   output logic                  proto_err,
   output logic                  decode_err,
   output logic [CNT_W-1:0]      wr_cnt,
   output logic [CNT_W-1:0]      rd_cnt
);

   localparam int                c_aw       = $clog2(DEPTH);
   localparam logic [APB_AW-1:0] c_win_mask = ~(APB_AW'(DEPTH * 4) - APB_AW'(1));
   localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   apb_state_e        r_state;
   logic [APB_AW-1:0] r_addr;
   logic              r_write;
   logic [APB_DW-1:0] r_wdata;
   logic              r_in_win;
   logic [APB_DW-1:0] r_prdata;
   logic              r_proto_err;
   logic              r_decode_err;
   logic [CNT_W-1:0]  r_wr_cnt;
   logic [CNT_W-1:0]  r_rd_cnt;

   // ------------------------------------------------------------------
   // Bus-cycle decode
   // ------------------------------------------------------------------
   logic              w_sel;
   logic              w_setup_cyc;
   logic              w_access_cyc;
   logic              w_acc_done;
   logic              w_live_in_win;
   logic              w_cmd_changed;
   logic              w_seq_viol;
   logic              w_viol;
   logic [c_aw-1:0]   w_live_idx;
   logic [c_aw-1:0]   w_lat_idx;
   logic [c_aw-1:0]   w_mem_addr;
   logic              w_mem_we;
   logic [APB_DW-1:0] w_mem_rdata;
   logic              w_unused_sel;

   assign w_sel        = bus.Pselx[SLV_IDX];
   assign w_setup_cyc  = w_sel & ~bus.Penable;
   assign w_access_cyc = w_sel &  bus.Penable;

   // Only bit SLV_IDX of the select vector decodes this slave.
   assign w_unused_sel = ^bus.Pselx;

   // A legal ACCESS is one that directly follows a SETUP cycle; this is the
   // edge on which the transfer completes.
   assign w_acc_done = (r_state == SETUP) & w_access_cyc;

   assign w_live_in_win = addr_in_win(bus.Paddr, BASE_ADDR, c_win_mask);
   assign w_live_idx    = bus.Paddr[2 +: c_aw];
   assign w_lat_idx     = r_addr[2 +: c_aw];

   // The master must hold the command stable from SETUP into ACCESS.
   assign w_cmd_changed = w_acc_done &
                          ((bus.Paddr  != r_addr)  |
                           (bus.Pwrite != r_write) |
                           (bus.Pwdata != r_wdata));

   // Illegal phase sequences: ACCESS without SETUP, SETUP repeated,
   // SETUP abandoned, or ACCESS held for a second cycle.
   assign w_seq_viol = ((r_state == IDLE)   & w_access_cyc) |
                       ((r_state == SETUP)  & w_setup_cyc)  |
                       ((r_state == SETUP)  & ~w_sel)       |
                       ((r_state == ACCESS) & w_access_cyc);

   assign w_viol = w_seq_viol | w_cmd_changed;

   // Single port: the write address is used only on an ACCESS-completion
   // edge, the read address only on a SETUP edge; the two never coincide.
   assign w_mem_addr = w_acc_done ? w_lat_idx : w_live_idx;
   assign w_mem_we   = w_acc_done & r_write & r_in_win;

   apb_slv_mem_array #(
      .DEPTH (DEPTH)
   ) u_mem_array (
      .clk   (Pclk),
      .we    (w_mem_we),
      .addr  (w_mem_addr),
      .wdata (r_wdata),
      .rdata (w_mem_rdata)
   );

   // Phase tracking, SETUP command latch, read data and error flags.
   always_ff @(posedge Pclk or posedge Preset) begin
      if (Preset) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_write      <= 1'b0;
         r_wdata      <= '0;
         r_in_win     <= 1'b0;
         r_prdata     <= '0;
         r_proto_err  <= 1'b0;
         r_decode_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_setup_cyc) begin
                  r_state <= SETUP;
               end else if (w_access_cyc) begin
                  r_state <= ACCESS;
               end else begin
                  r_state <= IDLE;
               end
            end
            SETUP: begin
               if (w_access_cyc) begin
                  r_state <= ACCESS;
               end else if (w_setup_cyc) begin
                  r_state <= SETUP;
               end else begin
                  r_state <= IDLE;
               end
            end
            ACCESS: begin
               if (w_setup_cyc) begin
                  r_state <= SETUP;
               end else if (w_access_cyc) begin
                  r_state <= ACCESS;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         // Every SETUP cycle (including a restarted one) captures the
         // command; reads fetch now so Prdata is valid throughout ACCESS.
         if (w_setup_cyc) begin
            r_addr   <= bus.Paddr;
            r_write  <= bus.Pwrite;
            r_wdata  <= bus.Pwdata;
            r_in_win <= w_live_in_win;
            if (!bus.Pwrite) begin
               r_prdata <= w_live_in_win ? w_mem_rdata : ERR_DATA;
            end
         end

         r_decode_err <= w_acc_done & ~r_in_win;

         // Sticky flag; a new violation overrides a simultaneous clear.
         if (w_viol) begin
            r_proto_err <= 1'b1;
         end else if (err_clr) begin
            r_proto_err <= 1'b0;
         end
      end
   end

   // Saturating completed-transfer counters (window hits and misses alike).
   always_ff @(posedge Pclk or posedge Preset) begin
      if (Preset) begin
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
      end else if (w_acc_done) begin
         if (r_write) begin
            if (r_wr_cnt != c_cnt_max) begin
               r_wr_cnt <= r_wr_cnt + c_cnt_one;
            end
         end else begin
            if (r_rd_cnt != c_cnt_max) begin
               r_rd_cnt <= r_rd_cnt + c_cnt_one;
            end
         end
      end
   end

   assign bus.Prdata = r_prdata;
   assign proto_err  = r_proto_err;
   assign decode_err = r_decode_err;
   assign wr_cnt     = r_wr_cnt;
   assign rd_cnt     = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_mem
// Desc     : Directed self-checking bench for apb_slave_mem. Read data is
//            predicted from a word-level memory model and queued when the
//            read is issued, then popped and compared in the ACCESS cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_mem;
   import apb_slv_pkg::*;

   localparam logic [31:0] c_base     = 32'h8000_0000;
   localparam logic [31:0] c_err_data = 32'hDEAD_BEEF;

   logic        Pclk = 1'b0;
   logic        Preset;
   logic        err_clr;
   logic        proto_err;
   logic        decode_err;
   logic [15:0] wr_cnt;
   logic [15:0] rd_cnt;

   int total = 0;
   int bad   = 0;
   int exp_wr = 0;
   int exp_rd = 0;

   logic [31:0] exp_q [$];
   logic [31:0] model [int];

   apb_slave_mem_if bus ();

   apb_slave_mem #(
      .SLV_IDX   (0),
      .BASE_ADDR (32'h8000_0000),
      .DEPTH     (256),
      .ERR_DATA  (32'hDEAD_BEEF)
   ) dut (
      .Pclk       (Pclk),
      .Preset     (Preset),
      .bus        (bus),
      .err_clr    (err_clr),
      .proto_err  (proto_err),
      .decode_err (decode_err),
      .wr_cnt     (wr_cnt),
      .rd_cnt     (rd_cnt)
   );

   always #5 Pclk = ~Pclk;

   // Abort guard in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (a[31:10] == c_base[31:10]);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic bus_idle();
      bus.Pselx   = 3'b000;
      bus.Penable = 1'b0;
      @(posedge Pclk); #1;
   endtask

   // Full write transfer; returns 1 time unit after the ACCESS edge.
   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      bus.Pselx   = 3'b001;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b1;
      bus.Paddr   = a;
      bus.Pwdata  = d;
      @(posedge Pclk); #1;
      bus.Penable = 1'b1;
      @(posedge Pclk); #1;
      if (in_win(a)) model[idx_of(a)] = d;
      exp_wr++;
   endtask

   // Full read transfer; expected data queued at SETUP, checked in ACCESS.
   task automatic apb_read(input logic [31:0] a, input string tag);
      logic [31:0] exp;
      bus.Pselx   = 3'b001;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b0;
      bus.Paddr   = a;
      if (in_win(a)) exp_q.push_back(model[idx_of(a)]);
      else           exp_q.push_back(c_err_data);
      @(posedge Pclk); #1;
      bus.Penable = 1'b1;
      @(negedge Pclk);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         exp = exp_q.pop_front();
         check(tag, bus.Prdata, exp);
      end
      @(posedge Pclk); #1;
      exp_rd++;
   endtask

   initial begin
      Preset      = 1'b1;
      err_clr     = 1'b0;
      bus.Pselx   = 3'b000;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b0;
      bus.Paddr   = '0;
      bus.Pwdata  = '0;
      repeat (2) @(posedge Pclk);
      @(negedge Pclk);
      check("rst_prdata",     bus.Prdata,        32'h0);
      check("rst_proto_err",  {31'b0, proto_err},  32'h0);
      check("rst_decode_err", {31'b0, decode_err}, 32'h0);
      check("rst_wr_cnt",     {16'b0, wr_cnt},     32'h0);
      check("rst_rd_cnt",     {16'b0, rd_cnt},     32'h0);
      @(posedge Pclk); #1;
      Preset = 1'b0;

      // Basic write then read back.
      apb_write(32'h8000_0010, 32'hA5A5_0001);
      apb_read (32'h8000_0010, "rd_basic");
      bus_idle();
      check("cnt_wr_basic", {16'b0, wr_cnt}, 32'(exp_wr));
      check("cnt_rd_basic", {16'b0, rd_cnt}, 32'(exp_rd));
      check("proto_clean",  {31'b0, proto_err}, 32'h0);

      // Byte-offset bits are ignored.
      apb_read(32'h8000_0012, "rd_lowbits");

      // Back-to-back write then read of the last word, no IDLE between.
      apb_write(32'h8000_03FC, 32'h1234_5678);
      apb_read (32'h8000_03FC, "rd_b2b_last");

      // Out-of-window write is dropped and flagged.
      apb_write(32'h8000_0400, 32'hFFFF_FFFF);
      check("dec_err_wr", {31'b0, decode_err}, 32'h1);
      apb_read(32'h8000_03FC, "rd_after_oow_wr");

      // Out-of-window read.
      apb_read(32'h9000_0000, "rd_oow");
      check("dec_err_rd", {31'b0, decode_err}, 32'h1);
      bus_idle();
      check("dec_err_pulse", {31'b0, decode_err}, 32'h0);
      check("cnt_wr_mid", {16'b0, wr_cnt}, 32'(exp_wr));
      check("cnt_rd_mid", {16'b0, rd_cnt}, 32'(exp_rd));
      apb_read(32'h8000_0010, "rd_unchanged");
      bus_idle();

      // ACCESS straight from IDLE: sticky error, no transfer.
      bus.Pselx   = 3'b001;
      bus.Penable = 1'b1;
      bus.Pwrite  = 1'b0;
      bus.Paddr   = 32'h8000_0010;
      @(posedge Pclk); #1;
      check("proto_set", {31'b0, proto_err}, 32'h1);
      bus_idle();
      bus_idle();
      check("proto_sticky", {31'b0, proto_err}, 32'h1);
      check("no_xfer_viol", {16'b0, rd_cnt}, 32'(exp_rd));
      err_clr = 1'b1;
      @(posedge Pclk); #1;
      err_clr = 1'b0;
      check("proto_clr", {31'b0, proto_err}, 32'h0);

      // Clear and a new violation together: the set wins.
      err_clr     = 1'b1;
      bus.Pselx   = 3'b001;
      bus.Penable = 1'b1;
      @(posedge Pclk); #1;
      check("proto_set_wins", {31'b0, proto_err}, 32'h1);
      bus.Pselx   = 3'b000;
      bus.Penable = 1'b0;
      @(posedge Pclk); #1;
      check("proto_clr2", {31'b0, proto_err}, 32'h0);
      err_clr = 1'b0;
      bus_idle();

      // Address changes between SETUP and ACCESS of a write.
      apb_write(32'h8000_0004, 32'h1111_0001);
      apb_write(32'h8000_0008, 32'h2222_0002);
      bus_idle();
      bus.Pselx   = 3'b001;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b1;
      bus.Paddr   = 32'h8000_0004;
      bus.Pwdata  = 32'h3333_0003;
      @(posedge Pclk); #1;
      bus.Penable = 1'b1;
      bus.Paddr   = 32'h8000_0008;
      @(posedge Pclk); #1;
      model[1] = 32'h3333_0003;
      check("proto_addr_chg", {31'b0, proto_err}, 32'h1);
      apb_read(32'h8000_0004, "rd_latched_idx");
      apb_read(32'h8000_0008, "rd_other_idx");

      // Reset asserted during the ACCESS of a write.
      apb_write(32'h8000_0020, 32'h0BAD_0020);
      apb_read (32'h8000_0010, "rd_pre_rst");
      bus.Pselx   = 3'b001;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b1;
      bus.Paddr   = 32'h8000_0020;
      bus.Pwdata  = 32'hCAFE_F00D;
      @(posedge Pclk); #1;
      bus.Penable = 1'b1;
      @(negedge Pclk);
      Preset = 1'b1;
      #1;
      check("mid_rst_prdata", bus.Prdata, 32'h0);
      check("mid_rst_proto",  {31'b0, proto_err}, 32'h0);
      check("mid_rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
      check("mid_rst_rd_cnt", {16'b0, rd_cnt}, 32'h0);
      @(posedge Pclk); #1;
      Preset = 1'b0;
      exp_wr = 0;
      exp_rd = 0;
      bus_idle();
      apb_read(32'h8000_0020, "rd_after_rst");
      bus_idle();
      check("cnt_rd_after_rst", {16'b0, rd_cnt}, 32'(exp_rd));
      check("cnt_wr_after_rst", {16'b0, wr_cnt}, 32'(exp_wr));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
